// File: rtl/serial_adder.sv
// Bit-serial add/subtract unit: one full-adder slice processes the operands LSB-first,
// one bit per clock, with a start/busy/done handshake and registered sum, carry and overflow.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] w_res_nxt;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_done;
  logic             r_cout;
  logic             r_ovf;
  logic             w_s;
  logic             w_co;
  logic             w_last;
  logic             w_accept;

  assign w_s      = r_opa[0] ^ r_opb[0] ^ r_carry;
  assign w_co     = (r_opa[0] & r_opb[0]) | (r_opa[0] & r_carry) | (r_opb[0] & r_carry);
  assign w_last   = (r_state == RUN) && (r_cnt == CNT_W'(WIDTH - 1));
  assign w_accept = (r_state == IDLE) && start;

  // New sum bit enters at the MSB; after WIDTH shifts the result is LSB-aligned.
  assign w_res_nxt = (WIDTH'(w_s) << (WIDTH - 1)) | (r_res >> 1);

  assign busy  = (r_state == RUN);
  assign done  = r_done;
  assign sum   = r_sum;
  assign c_out = r_cout;
  assign ovf   = r_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        // Subtraction is a + ~b + 1: invert B and force the initial carry.
        r_opa   <= a;
        r_opb   <= sub ? ~b : b;
        r_carry <= sub ? 1'b1 : c_in;
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        r_opa   <= r_opa >> 1;
        r_opb   <= r_opb >> 1;
        r_res   <= w_res_nxt;
        r_carry <= w_co;
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) begin
          // r_carry here is the carry into the MSB slice.
          r_sum  <= w_res_nxt;
          r_cout <= w_co;
          r_ovf  <= r_carry ^ w_co;
          r_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: WIDTH=8 vector table with a result scoreboard,
// handshake corner cases, and an exhaustive WIDTH=1 full-adder sweep.
module tb_serial_adder;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8_n, start8, sub8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       rst1_n, start1, sub1, cin1;
  logic [0:0] a1, b1;
  logic       busy1, done1, cout1, ovf1;
  logic [0:0] sum1;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst8_n), .start(start8), .sub(sub8), .a(a8), .b(b8), .c_in(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst1_n), .start(start1), .sub(sub1), .a(a1), .b(b1), .c_in(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1), .ovf(ovf1)
  );

  typedef struct {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  typedef struct {
    logic [7:0] s;
    logic       co;
    logic       ov;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   ndone8 = 0;
  exp_t q8[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Scoreboard: every done pulse of the 8-bit unit retires one expected result.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      exp_t e;
      ndone8++;
      if (q8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_done: got done=1 want no pending result");
      end else begin
        e = q8.pop_front();
        chk("sb_sum", sum8, e.s);
        chk("sb_cout", cout8, e.co);
        chk("sb_ovf", ovf8, e.ov);
      end
    end
  end

  // Called at #1 after a rising edge with the unit idle; returns #1 after the accepting edge.
  task automatic launch8(input logic s, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input bit push, input exp_t e);
    sub8 = s; a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    if (push) q8.push_back(e);
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic wait_done8(input logic [7:0] hold, output int lat, output int bcnt);
    bit ok;
    lat = 0; bcnt = 0; ok = 1'b1;
    while (done8 !== 1'b1 && lat < 20) begin
      if (busy8 === 1'b1) bcnt++;
      if (sum8 !== hold) ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk("done_seen", done8, 1'b1);
    chk("sum_held_during_run", ok, 1'b1);
  endtask

  vec_t vt[10];
  exp_t e;
  logic [7:0] prev;
  int lat, bcnt, n0, cyc, k;
  logic [1:0] fa;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{1'b0, 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1};
    vt[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[2] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[3] = '{1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0};
    vt[4] = '{1'b1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vt[5] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[6] = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[7] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vt[8] = '{1'b1, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[9] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

    rst8_n = 1'b0; start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    rst1_n = 1'b0; start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_sum", sum8, 8'h00);
    chk("rst_cout", cout8, 1'b0);
    chk("rst_ovf", ovf8, 1'b0);
    rst8_n = 1'b1; rst1_n = 1'b1;
    @(posedge clk); #1;

    // Table: each operation starts in the done cycle of the previous one.
    prev = 8'h00;
    for (int i = 0; i < 10; i++) begin
      e = '{vt[i].s, vt[i].co, vt[i].ov};
      launch8(vt[i].sub, vt[i].a, vt[i].b, vt[i].cin, 1'b1, e);
      wait_done8(prev, lat, bcnt);
      chk("latency", lat, 8);
      chk("busy_cycles", bcnt, 8);
      chk("busy_low_at_done", busy8, 1'b0);
      prev = vt[i].s;
    end
    @(posedge clk); #1;
    chk("done_one_cycle", done8, 1'b0);

    // Start while busy is ignored.
    repeat (2) @(posedge clk);
    #1;
    n0 = ndone8;
    launch8(1'b0, 8'h10, 8'h20, 1'b0, 1'b1, '{8'h30, 1'b0, 1'b0});
    @(posedge clk); #1;
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8(prev, lat, bcnt);
    chk("busy_start_sum", sum8, 8'h30);
    repeat (12) @(posedge clk);
    #1;
    chk("busy_start_one_done", ndone8 - n0, 1);
    prev = 8'h30;

    // Reset mid-operation aborts without a done pulse.
    launch8(1'b0, 8'h11, 8'h22, 1'b0, 1'b0, '{8'h33, 1'b0, 1'b0});
    repeat (3) @(posedge clk);
    #1;
    rst8_n = 1'b0;
    @(posedge clk); #1;
    rst8_n = 1'b1;
    chk("abort_busy", busy8, 1'b0);
    chk("abort_done", done8, 1'b0);
    chk("abort_sum", sum8, 8'h00);
    chk("abort_cout", cout8, 1'b0);
    chk("abort_ovf", ovf8, 1'b0);
    n0 = ndone8;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_done", ndone8 - n0, 0);
    launch8(1'b1, 8'h40, 8'h10, 1'b0, 1'b1, '{8'h30, 1'b1, 1'b0});
    wait_done8(8'h00, lat, bcnt);
    chk("after_abort_latency", lat, 8);
    prev = 8'h30;

    // Start held high: one operation every WIDTH+1 cycles.
    @(posedge clk); #1;
    sub8 = 1'b0; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
    for (int i = 0; i < 3; i++) q8.push_back('{8'h03, 1'b0, 1'b0});
    cyc = 0; k = 0;
    while (k < 3 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (done8 === 1'b1) k++;
    end
    start8 = 1'b0;
    chk("held_start_cycles", cyc, 27);
    repeat (12) @(posedge clk);
    #1;
    chk("queue_drained", q8.size(), 0);

    // WIDTH=1: exhaustive full-adder check, one-cycle latency.
    for (int i = 0; i < 8; i++) begin
      a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i);
      fa = 2'(a1) + 2'(b1) + 2'(cin1);
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      chk("w1_busy", busy1, 1'b1);
      chk("w1_done_early", done1, 1'b0);
      @(posedge clk); #1;
      chk("w1_done", done1, 1'b1);
      chk("w1_sum", sum1, fa[0]);
      chk("w1_cout", cout1, fa[1]);
      chk("w1_ovf", ovf1, cin1 ^ fa[1]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
